// File: rtl/mult_share_arbiter_if.sv
// Request/result bundle between two client datapaths and the shared multiplier arbiter.
// master = client side (drives requests and result ready), slave = arbiter side.
interface mult_share_arbiter_if #(
    parameter int W = 8
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   req_a0;
    logic [W-1:0]   req_b0;
    logic [W-1:0]   req_a1;
    logic [W-1:0]   req_b1;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_data;
    logic           res_id;
    logic           busy;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Two-requester round-robin front end for a single shared 8x8 unsigned array multiplier.
// One operation in flight: IDLE (arbitrate/accept) -> CALC (settle) -> DONE (hold result).
module unsigned_binary_array_multiplier #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] mul
);
    logic [2*W-1:0] partial [W];
    logic [2*W-1:0] acc;

    // Each row is a AND b[i], shifted into its column; rows are summed down the array.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            partial[i] = b[i] ? ({{W{1'b0}}, a} << i) : '0;
        end
        acc = '0;
        for (int i = 0; i < W; i++) begin
            acc = acc + partial[i];
        end
    end

    assign mul = acc;
endmodule

module mult_share_arbiter #(
    parameter int W           = 8,
    parameter int CALC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CALC_LAST = 4'(CALC_CYCLES - 1);

    logic [1:0]     state;
    logic           last_grant;
    logic [3:0]     calc_cnt;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_id;
    logic           res_valid;
    logic [2*W-1:0] res_data;
    logic           res_id;

    logic           grant;
    logic [1:0]     ready;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [2*W-1:0] product;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (&bus.req_valid) begin
            grant = ~last_grant;
        end else if (bus.req_valid[1]) begin
            grant = 1'b1;
        end

        ready = 2'b00;
        if ((state == IDLE) && !rst && (|bus.req_valid)) begin
            ready = grant ? 2'b10 : 2'b01;
        end

        sel_a = grant ? bus.req_a1 : bus.req_a0;
        sel_b = grant ? bus.req_b1 : bus.req_b0;
    end

    assign accept = |(bus.req_valid & ready);

    unsigned_binary_array_multiplier #(.W(W)) u_mult (
        .a   (op_a),
        .b   (op_b),
        .mul (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            calc_cnt   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        op_id      <= grant;
                        last_grant <= grant;
                        calc_cnt   <= '0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (calc_cnt == CALC_LAST) begin
                        calc_cnt  <= '0;
                        res_data  <= product;
                        res_id    <= op_id;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        calc_cnt <= calc_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // res_data deliberately keeps the last product after transfer; res_valid qualifies it.
    assign bus.req_ready = ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_id    = res_id;
    assign bus.busy      = (state != IDLE);
endmodule
